// File: rtl/unibus_pkg.sv
// Shared Unibus definitions: bus cycle C-codes and the DMA master state encoding.
package unibus_pkg;

  localparam logic [1:0] C_DATI  = 2'b00;
  localparam logic [1:0] C_DATIP = 2'b01;
  localparam logic [1:0] C_DATO  = 2'b10;
  localparam logic [1:0] C_DATOB = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_GRANT,
    S_WAITFREE,
    S_SETUP,
    S_WAITSSYN,
    S_LATCH,
    S_ENDCYC,
    S_HOLD,
    S_DONE
  } state_t;

  // DATIP is never issued by this master.
  function automatic logic [1:0] c_code(input logic write, input logic bsel);
    if (!write)     return C_DATI;
    else if (bsel)  return C_DATOB;
    else            return C_DATO;
  endfunction

endpackage

// File: rtl/unibus_dma_master.sv
// Unibus NPR bus master: one NPR arbitration followed by a single DATI/DATO/DATOB cycle.
module unibus_dma_master
  import unibus_pkg::*;
#(
  parameter int DESKEW  = 15,
  parameter int HOLD    = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        req_start,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [17:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_busy,
  output logic        req_done,
  output logic        req_err,
  output logic [15:0] req_rdata,
  input  logic        npg_in_l,
  output logic        npg_out_l,
  input  logic        bbsy_in_l,
  input  logic        sack_in_l,
  input  logic        ssyn_in_l,
  input  logic        init_in_l,
  input  logic [15:0] d_in_l,
  output logic        npr_out_h,
  output logic        sack_out_h,
  output logic        bbsy_out_h,
  output logic        msyn_out_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h
);

  localparam logic [15:0] DESKEW_END  = 16'(DESKEW - 1);
  localparam logic [15:0] HOLD_END    = 16'(HOLD - 1);
  localparam logic [15:0] TIMEOUT_END = 16'(TIMEOUT - 1);

  state_t      st, st_nx;
  logic [15:0] cnt;
  logic [17:0] addr_q;
  logic [15:0] wdata_q;
  logic        write_q, byte_q, err_q;
  logic        free, abort;

  // SACK is only driven, never sensed, by this master.
  logic unused_sack;
  assign unused_sack = sack_in_l;

  assign free      = bbsy_in_l & ssyn_in_l & npg_in_l;
  assign abort     = !init_in_l && (st != S_IDLE) && (st != S_DONE);
  assign npg_out_l = npg_in_l | npr_out_h | sack_out_h;

  assign req_done  = (st == S_DONE);
  assign req_busy  = (st != S_IDLE) && (st != S_DONE);
  assign req_err   = req_done & err_q;

  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE:     if (req_start) st_nx = S_REQ;
      S_REQ:      if (!npg_in_l) st_nx = S_GRANT;
      S_GRANT:    st_nx = S_WAITFREE;
      S_WAITFREE: if (free && cnt == DESKEW_END) st_nx = S_SETUP;
      S_SETUP:    if (cnt == DESKEW_END) st_nx = S_WAITSSYN;
      S_WAITSSYN: begin
        if (!ssyn_in_l)               st_nx = S_LATCH;
        else if (cnt == TIMEOUT_END)  st_nx = S_HOLD;
      end
      S_LATCH:    st_nx = S_ENDCYC;
      S_ENDCYC:   if (ssyn_in_l) st_nx = S_HOLD;
      S_HOLD:     if (cnt == HOLD_END) st_nx = S_DONE;
      S_DONE:     st_nx = S_IDLE;
      default:    st_nx = S_IDLE;
    endcase
    if (abort) st_nx = S_DONE;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      st         <= S_IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      byte_q     <= 1'b0;
      err_q      <= 1'b0;
      req_rdata  <= '0;
      npr_out_h  <= 1'b0;
      sack_out_h <= 1'b0;
      bbsy_out_h <= 1'b0;
      msyn_out_h <= 1'b0;
      a_out_h    <= '0;
      c_out_h    <= '0;
      d_out_h    <= '0;
    end else begin
      st <= st_nx;
      // Bus-free qualification restarts whenever any line is seen busy.
      if (st_nx != st || (st == S_WAITFREE && !free)) cnt <= '0;
      else                                             cnt <= cnt + 16'd1;

      if (abort) begin
        err_q      <= 1'b1;
        npr_out_h  <= 1'b0;
        sack_out_h <= 1'b0;
        bbsy_out_h <= 1'b0;
        msyn_out_h <= 1'b0;
        a_out_h    <= '0;
        c_out_h    <= '0;
        d_out_h    <= '0;
      end else begin
        case (st)
          S_IDLE: if (req_start) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            write_q   <= req_write;
            byte_q    <= req_byte;
            err_q     <= 1'b0;
            npr_out_h <= 1'b1;
          end
          S_REQ: if (!npg_in_l) begin
            npr_out_h  <= 1'b0;
            sack_out_h <= 1'b1;
          end
          S_WAITFREE: if (st_nx == S_SETUP) begin
            bbsy_out_h <= 1'b1;
            sack_out_h <= 1'b0;
            a_out_h    <= addr_q;
            c_out_h    <= c_code(write_q, byte_q);
            d_out_h    <= write_q ? wdata_q : 16'd0;
          end
          S_SETUP: if (st_nx == S_WAITSSYN) msyn_out_h <= 1'b1;
          S_WAITSSYN: if (st_nx == S_HOLD) begin
            msyn_out_h <= 1'b0;
            err_q      <= 1'b1;
          end
          // Data is taken one cycle after SSYN to give the slave's drivers a deskew slot.
          S_LATCH: begin
            msyn_out_h <= 1'b0;
            if (!write_q) req_rdata <= ~d_in_l;
          end
          S_HOLD: if (st_nx == S_DONE) begin
            bbsy_out_h <= 1'b0;
            a_out_h    <= '0;
            c_out_h    <= '0;
            d_out_h    <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_unibus_dma_master.sv
// Bench for unibus_dma_master: CPU grant model, ROM/RAM slave model, vector table and scoreboard.
module tb_unibus_dma_master;
  import unibus_pkg::*;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLOCK = ~CLOCK;

  logic        req_start = 1'b0, req_write = 1'b0, req_byte = 1'b0;
  logic [17:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_busy, req_done, req_err;
  logic [15:0] req_rdata;
  logic        npg_in_l, npg_out_l, bbsy_in_l, sack_in_l, ssyn_in_l, init_in_l;
  logic [15:0] d_in_l;
  logic        npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h;
  logic [17:0] a_out_h;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h;

  logic manual = 1'b0, npg_manual = 1'b1, init_l = 1'b1;
  logic npg_arb, slv_ssyn_l;
  logic [15:0] slv_d_l;

  assign npg_in_l  = manual ? npg_manual : npg_arb;
  assign bbsy_in_l = ~bbsy_out_h;
  assign sack_in_l = ~sack_out_h;
  assign ssyn_in_l = slv_ssyn_l;
  assign d_in_l    = slv_d_l & ~d_out_h;
  assign init_in_l = init_l;

  unibus_dma_master dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .req_start(req_start), .req_write(req_write), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_busy(req_busy), .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
    .npg_in_l(npg_in_l), .npg_out_l(npg_out_l),
    .bbsy_in_l(bbsy_in_l), .sack_in_l(sack_in_l), .ssyn_in_l(ssyn_in_l), .init_in_l(init_in_l),
    .d_in_l(d_in_l),
    .npr_out_h(npr_out_h), .sack_out_h(sack_out_h), .bbsy_out_h(bbsy_out_h), .msyn_out_h(msyn_out_h),
    .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h)
  );

  // CPU arbiter: grant NPG a few cycles after NPR, withdraw once SACK is seen.
  logic [2:0] arb_cnt;
  always @(posedge CLOCK) begin
    if (RESET || sack_out_h || !npr_out_h) begin
      npg_arb <= 1'b1;
      arb_cnt <= '0;
    end else if (arb_cnt == 3'd3) npg_arb <= 1'b0;
    else arb_cnt <= arb_cnt + 3'd1;
  end

  // Slave: M9312-style ROM word at 765000, RAM below 010000, nothing elsewhere.
  logic [15:0] mem [0:2047];
  logic [1:0]  sdly;
  function automatic logic exists(input logic [17:0] a);
    return (a == 18'o765000) || (a < 18'o010000);
  endfunction
  always @(posedge CLOCK) begin
    if (RESET) begin
      slv_ssyn_l <= 1'b1;
      slv_d_l    <= '1;
      sdly       <= '0;
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
    end else if (msyn_out_h && slv_ssyn_l && exists(a_out_h)) begin
      sdly <= sdly + 2'd1;
      if (sdly == 2'd3) begin
        slv_ssyn_l <= 1'b0;
        case (c_out_h)
          C_DATI:  slv_d_l <= (a_out_h == 18'o765000) ? ~16'o173000 : ~mem[a_out_h[11:1]];
          C_DATO:  mem[a_out_h[11:1]] <= d_out_h;
          C_DATOB: if (a_out_h[0]) mem[a_out_h[11:1]][15:8] <= d_out_h[15:8];
                   else            mem[a_out_h[11:1]][7:0]  <= d_out_h[7:0];
          default: ;
        endcase
      end
    end else if (!msyn_out_h && !slv_ssyn_l) begin
      slv_ssyn_l <= 1'b1;
      slv_d_l    <= '1;
      sdly       <= '0;
    end else sdly <= '0;
  end

  typedef struct {
    logic        wr, bt;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  c;
    logic        err, chk;
    logic [15:0] rdata;
  } vec_t;
  typedef struct { logic err; logic chk; logic [15:0] rdata; } exp_t;

  exp_t sb[$];
  int   nvec = 0, nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0o, expected %0o", nm, act, exp);
    end
  endtask

  task automatic start(input logic wr, input logic bt, input logic [17:0] a, input logic [15:0] wd);
    @(negedge CLOCK);
    req_write = wr; req_byte = bt; req_addr = a; req_wdata = wd; req_start = 1'b1;
    @(negedge CLOCK);
    req_start = 1'b0;
  endtask

  task automatic check_done(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_unexpected_done"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_err"}, 32'(req_err), 32'(e.err));
    chk({nm, "_busy_at_done"}, 32'(req_busy), 32'd0);
    if (e.chk) chk({nm, "_rdata"}, 32'(req_rdata), 32'(e.rdata));
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int t_npr = -1, t_npg = -1, t_sack = -1, t_bbsy = -1, t_mr = -1, t_mf = -1;
    logic [1:0]  c_at = '0;
    logic [15:0] d_at = '0;
    logic got = 1'b0;
    string nm = $sformatf("v%0d", idx);
    sb.push_back('{v.err, v.chk, v.rdata});
    start(v.wr, v.bt, v.addr, v.wdata);
    for (int t = 1; t < 5000 && !got; t++) begin
      if (npr_out_h  && t_npr  < 0) t_npr  = t;
      if (!npg_in_l  && t_npg  < 0) t_npg  = t;
      if (sack_out_h && t_sack < 0) t_sack = t;
      if (bbsy_out_h && t_bbsy < 0) t_bbsy = t;
      if (msyn_out_h && t_mr < 0) begin t_mr = t; c_at = c_out_h; d_at = d_out_h; end
      if (!msyn_out_h && t_mr >= 0 && t_mf < 0) t_mf = t;
      if (req_done) begin got = 1'b1; check_done(nm); end
      else @(negedge CLOCK);
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_arb_order"}, 32'(t_npr >= 0 && t_npr < t_npg && t_npg < t_sack && t_sack < t_bbsy), 32'd1);
    chk({nm, "_deskew"}, 32'(t_bbsy >= 0 && t_mr - t_bbsy >= 15), 32'd1);
    chk({nm, "_c_code"}, 32'(c_at), 32'(v.c));
    if (v.wr) chk({nm, "_d_drive"}, 32'(d_at), 32'(v.wdata));
    if (v.err) chk({nm, "_msyn_width"}, 32'(t_mf - t_mr), 32'd1000);
    @(negedge CLOCK);
    chk({nm, "_released"}, 32'({npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, c_out_h} != 0 ||
                               a_out_h != 0 || d_out_h != 0 || req_busy || req_done), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    int  ndone;
    logic ok;
    vecs[0] = '{1'b0, 1'b0, 18'o765000, 16'o000000, C_DATI,  1'b0, 1'b1, 16'o173000};
    vecs[1] = '{1'b1, 1'b0, 18'o001000, 16'o052525, C_DATO,  1'b0, 1'b0, 16'o000000};
    vecs[2] = '{1'b0, 1'b0, 18'o001000, 16'o000000, C_DATI,  1'b0, 1'b1, 16'o052525};
    vecs[3] = '{1'b1, 1'b1, 18'o001001, 16'o177400, C_DATOB, 1'b0, 1'b0, 16'o000000};
    vecs[4] = '{1'b0, 1'b0, 18'o001000, 16'o000000, C_DATI,  1'b0, 1'b1, 16'o177525};
    vecs[5] = '{1'b0, 1'b0, 18'o760000, 16'o000000, C_DATI,  1'b1, 1'b0, 16'o000000};
    vecs[6] = '{1'b1, 1'b0, 18'o001002, 16'o123456, C_DATO,  1'b0, 1'b0, 16'o000000};
    vecs[7] = '{1'b1, 1'b1, 18'o001002, 16'o000077, C_DATOB, 1'b0, 1'b0, 16'o000000};
    vecs[8] = '{1'b0, 1'b0, 18'o001002, 16'o000000, C_DATI,  1'b0, 1'b1, 16'o123477};

    repeat (4) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("reset_drives", 32'({npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, c_out_h} != 0 ||
                            a_out_h != 0 || d_out_h != 0), 32'd0);
    chk("reset_req", 32'({req_busy, req_done, req_err}), 32'd0);
    chk("reset_rdata", 32'(req_rdata), 32'd0);
    RESET = 1'b0;

    // Grant passes straight through while idle.
    manual = 1'b1; npg_manual = 1'b0;
    @(negedge CLOCK);
    chk("chain_low", 32'(npg_out_l), 32'd0);
    chk("chain_idle", 32'({req_busy, npr_out_h, sack_out_h}), 32'd0);
    npg_manual = 1'b1;
    @(negedge CLOCK);
    chk("chain_high", 32'(npg_out_l), 32'd1);
    manual = 1'b0;

    for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

    // Second start while busy must be ignored.
    sb.push_back('{1'b0, 1'b1, 16'o173000});
    start(1'b0, 1'b0, 18'o765000, 16'o0);
    repeat (4) @(negedge CLOCK);
    chk("busy_before_2nd", 32'(req_busy), 32'd1);
    start(1'b1, 1'b0, 18'o001000, 16'o111111);
    ndone = 0;
    for (int t = 0; t < 600; t++) begin
      if (req_done) begin ndone++; check_done("busy"); end
      @(negedge CLOCK);
    end
    chk("busy_one_done", 32'(ndone), 32'd1);

    // INIT pulled during WAITSSYN against a nonexistent address.
    sb.push_back('{1'b1, 1'b0, 16'o0});
    start(1'b0, 1'b0, 18'o760000, 16'o0);
    ok = 1'b0;
    for (int t = 0; t < 500 && !ok; t++) begin
      if (msyn_out_h) ok = 1'b1;
      else @(negedge CLOCK);
    end
    chk("init_msyn_seen", 32'(ok), 32'd1);
    repeat (10) @(negedge CLOCK);
    init_l = 1'b0;
    @(negedge CLOCK);
    chk("init_drives", 32'({npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, c_out_h} != 0 ||
                           a_out_h != 0 || d_out_h != 0), 32'd0);
    chk("init_done", 32'(req_done), 32'd1);
    if (req_done) check_done("init");
    init_l = 1'b1;
    @(negedge CLOCK);
    chk("init_idle", 32'({req_busy, req_done}), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
